// File: rtl/lf_adder_pipe.sv
// lf_adder_pipe: pipelined Ladner-Fischer parallel-prefix adder with
// valid/ready handshaking on both sides.
//
// Pipeline (L = log2(WIDTH)):
//   stage 0      : bitwise generate/propagate; carry_in is folded into bit 0
//   stage 1..L   : one Ladner-Fischer prefix level each
//   stage L+1    : sum register (drives sum/out_valid)
// A single global stall (out_valid & ~out_ready) freezes every stage.
//
// Optional feature: define LF_ADDER_PIPE_SUB_EN to add the sub_mode input.
// With sub_mode=1 the block computes num1 + ~num2 + 1, so sum[WIDTH] is the
// "no borrow" flag.
module lf_adder_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   input  logic             carry_in,
`ifdef LF_ADDER_PIPE_SUB_EN
   input  logic             sub_mode,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH:0]   sum,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int L = $clog2(WIDTH);

   // Reject widths that are not a power of two in 2..64.
   generate
      if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
         $error("lf_adder_pipe: WIDTH must be a power of two in 2..64");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic stall;
   logic adv;
   logic out_valid_q;
   logic [WIDTH:0] sum_q;

   assign stall     = out_valid_q & ~out_ready;
   assign adv       = ~stall;
   assign in_ready  = ~stall;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;

   // ------------------------------------------------------------------
   // Operand conditioning (optional subtract)
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

`ifdef LF_ADDER_PIPE_SUB_EN
   // Subtract as num1 + ~num2 + 1; carry_in is ignored in that mode.
   assign b_eff   = sub_mode ? ~num2 : num2;
   assign cin_eff = sub_mode ? 1'b1 : carry_in;
`else
   assign b_eff   = num2;
   assign cin_eff = carry_in;
`endif

   // Bitwise generate/propagate. Folding carry_in into the bit-0 generate
   // lets the prefix tree stay at exactly L levels over WIDTH bits; the
   // prefix output at bit i is then the carry out of bit i.
   logic [WIDTH-1:0] prop_d;
   logic [WIDTH-1:0] gen_d;

   assign prop_d = num1 ^ b_eff;
   assign gen_d  = (num1 & b_eff) | {{(WIDTH-1){1'b0}}, prop_d[0] & cin_eff};

   // ------------------------------------------------------------------
   // Stage registers. Index 0 is the g/p stage, index s is after level s.
   // g_q/p_q hold group generate/propagate, pb_q the original bit
   // propagate (needed for the final XOR), cin_q the operand carry-in.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] g_q  [0:L];
   logic [WIDTH-1:0] p_q  [0:L];
   logic [WIDTH-1:0] pb_q [0:L];
   logic             cin_q[0:L];
   logic [L:0]       v_q;

   logic [WIDTH-1:0] g_d  [1:L];
   logic [WIDTH-1:0] p_d  [1:L];

   // Ladner-Fischer prefix levels: at level s (span 2^(s-1)) every bit in
   // the upper half of each 2^s block combines with the top bit of the
   // lower half of that block; all other bits pass straight through.
   generate
      for (genvar gs = 1; gs <= L; gs++) begin : g_level
         for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (((gi >> (gs - 1)) & 1) == 1) begin : g_node
               localparam int J = ((gi >> (gs - 1)) << (gs - 1)) - 1;
               assign g_d[gs][gi] = g_q[gs-1][gi] | (p_q[gs-1][gi] & g_q[gs-1][J]);
               assign p_d[gs][gi] = p_q[gs-1][gi] & p_q[gs-1][J];
            end else begin : g_pass
               assign g_d[gs][gi] = g_q[gs-1][gi];
               assign p_d[gs][gi] = p_q[gs-1][gi];
            end
         end
      end
   endgenerate

   // Advance the data registers of the g/p and prefix stages when not stalled.
   always_ff @(posedge clk) begin
      if (adv) begin
         g_q[0]   <= gen_d;
         p_q[0]   <= prop_d;
         pb_q[0]  <= prop_d;
         cin_q[0] <= cin_eff;
         for (int s = 1; s <= L; s++) begin
            g_q[s]   <= g_d[s];
            p_q[s]   <= p_d[s];
            pb_q[s]  <= pb_q[s-1];
            cin_q[s] <= cin_q[s-1];
         end
      end
   end

   // Stage valid bits: shift in in_valid (bubbles included), clear on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q <= '0;
      end else if (adv) begin
         v_q <= {v_q[L-1:0], in_valid};
      end
   end

   // ------------------------------------------------------------------
   // Sum stage
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] carry_vec;
   logic [WIDTH:0]   sum_d;

   assign carry_vec = {g_q[L][WIDTH-2:0], cin_q[L]};
   assign sum_d     = {g_q[L][WIDTH-1], pb_q[L] ^ carry_vec};

   // Group propagate after the last level has no consumer.
   logic unused_p;
   assign unused_p = ^p_q[L];

   // Output register: sum only loads on a real result so it keeps its last
   // value across bubbles and holds while the consumer stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
      end else if (adv) begin
         out_valid_q <= v_q[L];
         if (v_q[L]) begin
            sum_q <= sum_d;
         end
      end
   end

endmodule

// File: tb/tb_lf_adder_pipe.sv
// tb_lf_adder_pipe: scoreboard bench for lf_adder_pipe (WIDTH=8 main
// instance, WIDTH=32 instance for the wide carry-ripple case).
// Define LF_ADDER_PIPE_SUB_EN to also exercise the subtract mode.
// Latency is counted in rising edges with the accepting edge as edge 1.
module tb_lf_adder_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] num1, num2;
   logic       carry_in, in_valid, in_ready;
   logic [8:0] sum;
   logic       out_valid, out_ready;
`ifdef LF_ADDER_PIPE_SUB_EN
   logic       sub_mode;
   logic       sub_mode32;
`endif

   logic [31:0] a32, b32;
   logic        cin32, iv32, ir32, ov32, or32;
   logic [32:0] sum32;

   lf_adder_pipe #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .num1      (num1),
      .num2      (num2),
      .carry_in  (carry_in),
`ifdef LF_ADDER_PIPE_SUB_EN
      .sub_mode  (sub_mode),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum       (sum),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   lf_adder_pipe #(.WIDTH(32)) dut32 (
      .clk       (clk),
      .rst_n     (rst_n),
      .num1      (a32),
      .num2      (b32),
      .carry_in  (cin32),
`ifdef LF_ADDER_PIPE_SUB_EN
      .sub_mode  (sub_mode32),
`endif
      .in_valid  (iv32),
      .in_ready  (ir32),
      .sum       (sum32),
      .out_valid (ov32),
      .out_ready (or32)
   );

   int n_vec = 0;
   int n_err = 0;
   int n_out = 0;
   logic [8:0] sb_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic s);
      logic [7:0] nb;
      nb = ~b;
      if (s) return {1'b0, a} + {1'b0, nb} + 9'd1;
      return {1'b0, a} + {1'b0, b} + {8'd0, c};
   endfunction

   logic sm_now;
`ifdef LF_ADDER_PIPE_SUB_EN
   assign sm_now = sub_mode;
`else
   assign sm_now = 1'b0;
`endif

   // Monitor/scoreboard: push on acceptance, pop on consumption.
   logic       prev_rst_n = 1'b0;
   logic       prev_stall = 1'b0;
   logic [8:0] held_sum   = '0;
   logic [8:0] last_sum   = '0;
   always @(negedge clk) begin
      logic [8:0] exp_v;
      if (!prev_rst_n) begin
         check_eq("rst_out_valid", out_valid, 1'b0);
         check_eq("rst_sum", sum, 9'd0);
         check_eq("rst_in_ready", in_ready, 1'b1);
      end else begin
         check_eq("in_ready", in_ready, !(out_valid && !out_ready));
         if (prev_stall) begin
            check_eq("hold_valid", out_valid, 1'b1);
            check_eq("hold_sum", sum, held_sum);
         end
         if (!out_valid) check_eq("retain_sum", sum, last_sum);
      end
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            check_eq("sb_expected", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
               exp_v = sb_q.pop_front();
               check_eq("sum", sum, exp_v);
               n_out++;
               $display("txn %0d: sum=0x%03h expected 0x%03h", n_out, sum, exp_v);
            end
         end
         if (in_valid && in_ready) sb_q.push_back(model(num1, num2, carry_in, sm_now));
      end
      prev_stall = rst_n && out_valid && !out_ready;
      held_sum   = sum;
      last_sum   = sum;
      prev_rst_n = rst_n;
   end

   // Present one operand set and hold it until accepted; returns 1 time
   // unit after the accepting edge with in_valid dropped.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic ok;
      ok = 1'b0;
      num1 = a; num2 = b; carry_in = c; in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("accept", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic latency_test(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input logic [8:0] exp_sum);
      int n;
      n = 0;
      send(a, b, c);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (out_valid) begin
            n = k;
            break;
         end
      end
      check_eq("latency", n, 5);
      check_eq("lat_sum", sum, exp_sum);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; num1 = '0; num2 = '0; carry_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a32 = '0; b32 = '0; cin32 = 1'b0; iv32 = 1'b0; or32 = 1'b1;
`ifdef LF_ADDER_PIPE_SUB_EN
      sub_mode = 1'b0; sub_mode32 = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single transactions with latency measurement.
      latency_test(8'h58, 8'hBB, 1'b0, 9'h113);
      latency_test(8'hFF, 8'h00, 1'b1, 9'h100);

      // Four back-to-back inputs produce four consecutive results.
      send(8'h01, 8'h02, 1'b0);
      send(8'h03, 8'h04, 1'b0);
      send(8'h80, 8'h80, 1'b0);
      send(8'hFF, 8'hFF, 1'b0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      check_eq("b2b_first", out_valid, 1'b1);
      check_eq("b2b_sum0", sum, 9'h003);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq("b2b_valid", out_valid, 1'b1);
      end
      check_eq("b2b_sum3", sum, 9'h1FE);
      repeat (10) @(posedge clk);
      #1;

      // Downstream stall while inputs keep arriving.
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(8'(i * 37 + 5), 8'(i * 11 + 200), 1'(i));
         end
         begin
            for (int k = 0; k < 30; k++) begin
               @(negedge clk);
               if (out_valid) break;
            end
            check_eq("stall_reach", out_valid, 1'b1);
            repeat (3) begin
               @(negedge clk);
               check_eq("stall_in_ready", in_ready, 1'b0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      repeat (15) @(posedge clk);
      check_eq("stall_drain", sb_q.size(), 0);
      #1;

      // Reset with three transactions in flight: none may ever emerge.
      send(8'h11, 8'h22, 1'b0);
      send(8'h33, 8'h44, 1'b1);
      send(8'h55, 8'h66, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (15) begin
         @(negedge clk);
         check_eq("no_ghost", out_valid, 1'b0);
      end
      @(posedge clk); #1;

`ifdef LF_ADDER_PIPE_SUB_EN
      // Subtract mode.
      sub_mode = 1'b1;
      send(8'h58, 8'hBB, 1'b1);
      send(8'hBB, 8'h58, 1'b0);
      sub_mode = 1'b0;
      repeat (10) @(posedge clk);
      #1;
`endif

      // Random traffic with bubbles and random backpressure.
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk); #1;
               end
`ifdef LF_ADDER_PIPE_SUB_EN
               sub_mode = 1'($urandom_range(0, 1));
`endif
               send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            end
         end
         begin
            repeat (150) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      repeat (20) @(posedge clk);
      check_eq("final_drain", sb_q.size(), 0);
      #1;

      // WIDTH=32 carry through all bits.
      a32 = 32'hFFFF_FFFF; b32 = 32'h1; cin32 = 1'b0; iv32 = 1'b1;
      @(negedge clk);
      check_eq("w32_in_ready", ir32, 1'b1);
      @(posedge clk); #1;
      iv32 = 1'b0;
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (ov32) begin
            n = k;
            break;
         end
      end
      check_eq("w32_latency", n, 7);
      check_eq("w32_sum", sum32, 33'h1_0000_0000);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
